// File: rtl/jts16_scr_pkg.sv
// Shared definitions for the S16 scroll layers: row-scroll FSM states and the
// text RAM table bases holding the per-row horizontal scroll words.
package jts16_scr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH1 = 2'd1,
        FETCH2 = 2'd2,
        COMMIT = 2'd3
    } rowscr_st_t;

    localparam logic [10:0] ROWSCR1_BASE = 11'h7C0;
    localparam logic [10:0] ROWSCR2_BASE = 11'h7E0;

    // One table entry per 8-line row; the index wraps every 256 lines.
    function automatic logic [10:0] rowscr_addr(input logic [10:0] base, input logic [4:0] row);
        return base + {6'd0, row};
    endfunction

endpackage

// File: rtl/jts16_rowscr.sv
// Per-line scroll latch for the two S16 tilemap layers. Row-scroll fetches from
// text RAM are built only when JTS16_ROWSCR_EN is defined.
module jts16_rowscr
    import jts16_scr_pkg::*;
#(
    parameter int MODEL = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic [8:0]  vdump,
    input  logic [15:0] scr1_hpos,
    input  logic [15:0] scr2_hpos,
    input  logic [15:0] scr1_vpos,
    input  logic [15:0] scr2_vpos,
    input  logic        rowscr1_en,
    input  logic        rowscr2_en,
    output logic [11:1] ram_addr,
    output logic        ram_rd,
    input  logic [15:0] ram_din,
    input  logic        ram_ok,
    output logic [9:0]  hpos1,
    output logic [9:0]  hpos2,
    output logic [8:0]  vpos1,
    output logic [8:0]  vpos2,
    output logic        pos_ok
);

    rowscr_st_t st;
    logic       hs_l;
    logic       line_start;
    logic [9:0] nh1, nh2;
    logic [8:0] nv1, nv2;
    logic       unused_bits;

    assign line_start = hs & ~hs_l;

`ifdef JTS16_ROWSCR_EN
    logic        rd;
    logic [11:1] addr;
    logic        fetch1_en, fetch2_en;

    assign fetch1_en   = (MODEL != 0) && rowscr1_en;
    assign fetch2_en   = (MODEL != 0) && rowscr2_en;
    assign ram_rd      = rd;
    assign ram_addr    = addr;
    assign unused_bits = ^{scr1_hpos[15:10], scr2_hpos[15:10], scr1_vpos[15:9],
                           scr2_vpos[15:9], ram_din[15:10], vdump[8], vdump[2:0]};
`else
    assign ram_rd      = 1'b0;
    assign ram_addr    = '0;
    assign unused_bits = ^{scr1_hpos[15:10], scr2_hpos[15:10], scr1_vpos[15:9],
                           scr2_vpos[15:9], ram_din, ram_ok, vdump,
                           rowscr1_en, rowscr2_en, (MODEL != 0)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            hs_l   <= 1'b0;
            nh1    <= '0;
            nh2    <= '0;
            nv1    <= '0;
            nv2    <= '0;
            hpos1  <= '0;
            hpos2  <= '0;
            vpos1  <= '0;
            vpos2  <= '0;
            pos_ok <= 1'b0;
`ifdef JTS16_ROWSCR_EN
            rd     <= 1'b0;
            addr   <= '0;
`endif
        end else begin
            hs_l <= hs;
            // A new line start wins over any state, abandoning an unfinished fetch.
            if (line_start) begin
                nh1    <= scr1_hpos[9:0];
                nh2    <= scr2_hpos[9:0];
                nv1    <= scr1_vpos[8:0];
                nv2    <= scr2_vpos[8:0];
                pos_ok <= 1'b0;
`ifdef JTS16_ROWSCR_EN
                rd     <= 1'b0;
                st     <= FETCH1;
`else
                st     <= COMMIT;
`endif
            end else begin
                case (st)
`ifdef JTS16_ROWSCR_EN
                    FETCH1: begin
                        if (!fetch1_en) begin
                            rd <= 1'b0;
                            st <= FETCH2;
                        end else if (!rd) begin
                            rd   <= 1'b1;
                            addr <= rowscr_addr(ROWSCR1_BASE, vdump[7:3]);
                        end else if (ram_ok) begin
                            nh1 <= ram_din[9:0];
                            rd  <= 1'b0;
                            st  <= FETCH2;
                        end
                    end
                    FETCH2: begin
                        if (!fetch2_en) begin
                            rd <= 1'b0;
                            st <= COMMIT;
                        end else if (!rd) begin
                            rd   <= 1'b1;
                            addr <= rowscr_addr(ROWSCR2_BASE, vdump[7:3]);
                        end else if (ram_ok) begin
                            nh2 <= ram_din[9:0];
                            rd  <= 1'b0;
                            st  <= COMMIT;
                        end
                    end
`endif
                    COMMIT: begin
                        hpos1  <= nh1;
                        hpos2  <= nh2;
                        vpos1  <= nv1;
                        vpos2  <= nv2;
                        pos_ok <= 1'b1;
                        st     <= IDLE;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jts16_rowscr.sv
// Directed bench for jts16_rowscr: line latch, row-scroll fetch order and data,
// abort on a new line, asynchronous reset. Fetch cases need JTS16_ROWSCR_EN.
module tb_jts16_rowscr;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs;
    logic [8:0]  vdump;
    logic [15:0] scr1_hpos, scr2_hpos, scr1_vpos, scr2_vpos;
    logic        rowscr1_en, rowscr2_en;
    logic [11:1] ram_addr;
    logic        ram_rd;
    logic [15:0] ram_din;
    logic        ram_ok;
    logic [9:0]  hpos1, hpos2;
    logic [8:0]  vpos1, vpos2;
    logic        pos_ok;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ok_lat = 1;
    int          commits = 0;
    bit          rd_seen = 1'b0;
    logic [10:0] rd_addrs[$];
    logic        rd_q = 1'b0;
    logic        pos_q = 1'b0;

    jts16_rowscr #(.MODEL(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .hs         (hs),
        .vdump      (vdump),
        .scr1_hpos  (scr1_hpos),
        .scr2_hpos  (scr2_hpos),
        .scr1_vpos  (scr1_vpos),
        .scr2_vpos  (scr2_vpos),
        .rowscr1_en (rowscr1_en),
        .rowscr2_en (rowscr2_en),
        .ram_addr   (ram_addr),
        .ram_rd     (ram_rd),
        .ram_din    (ram_din),
        .ram_ok     (ram_ok),
        .hpos1      (hpos1),
        .hpos2      (hpos2),
        .vpos1      (vpos1),
        .vpos2      (vpos2),
        .pos_ok     (pos_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Text RAM contents: one hand-picked word, the rest a fixed xor pattern.
    function automatic logic [15:0] ram_word(input logic [10:0] a);
        if (a == 11'h7C5) return 16'h02AA;
        return 16'hA155 ^ {5'd0, a};
    endfunction

    // RAM model: ok is high during the ok_lat-th cycle of a request, for one cycle.
    initial begin : responder
        int cnt;
        cnt     = 0;
        ram_ok  = 1'b0;
        ram_din = '0;
        forever begin
            tick();
            if (ram_rd && !ram_ok) begin
                cnt++;
                if (cnt >= ok_lat) begin
                    ram_ok  = 1'b1;
                    ram_din = ram_word(ram_addr);
                    cnt     = 0;
                end
            end else begin
                ram_ok = 1'b0;
                cnt    = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (ram_rd && !rd_q) begin
            rd_seen = 1'b1;
            rd_addrs.push_back(ram_addr);
        end
        if (pos_ok && !pos_q) commits++;
        rd_q  = ram_rd;
        pos_q = pos_ok;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Raises hs and counts clocks from the detecting edge until pos_ok rises.
    task automatic line_edge(output int lat);
        logic [9:0] h1_old, h2_old;
        logic [8:0] v1_old;
        bit         partial;
        h1_old  = hpos1;
        h2_old  = hpos2;
        v1_old  = vpos1;
        partial = 1'b0;
        lat     = 0;
        hs = 1'b1;
        tick();
        check("pos_clr_on_line", 32'(pos_ok), 32'h0);
        for (int i = 0; i < 60 && !pos_ok; i++) begin
            tick();
            lat++;
            if (!pos_ok && (hpos1 !== h1_old || hpos2 !== h2_old || vpos1 !== v1_old))
                partial = 1'b1;
        end
        check("pos_ok_rise", 32'(pos_ok), 32'h1);
        check("no_partial", 32'(partial), 32'h0);
    endtask

    initial begin : stimulus
        int lat;
        int c0;
        rst = 1'b1; hs = 1'b0; vdump = '0;
        scr1_hpos = '0; scr2_hpos = '0; scr1_vpos = '0; scr2_vpos = '0;
        rowscr1_en = 1'b0; rowscr2_en = 1'b0;
        repeat (3) tick();
        check("rst_ram_rd",   32'(ram_rd),   32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_pos_ok",   32'(pos_ok),   32'h0);
        check("rst_hpos1",    32'(hpos1),    32'h0);
        check("rst_vpos2",    32'(vpos2),    32'h0);
        rst = 1'b0;
        tick();

        // Plain latch, no fetches; hs then held high must not retrigger.
        scr1_hpos = 16'h0123; scr1_vpos = 16'h0045;
        scr2_hpos = 16'hF2BC; scr2_vpos = 16'hAB67;
        vdump = 9'h010;
        rd_seen = 1'b0; commits = 0;
        line_edge(lat);
`ifdef JTS16_ROWSCR_EN
        check("lat_nofetch", 32'(lat), 32'd3);
`else
        check("lat_nofetch", 32'(lat), 32'd1);
`endif
        check("t1_hpos1", 32'(hpos1), 32'h123);
        check("t1_vpos1", 32'(vpos1), 32'h045);
        check("t1_hpos2", 32'(hpos2), 32'h2BC);
        check("t1_vpos2", 32'(vpos2), 32'h167);
        repeat (5) tick();
        check("hs_hold_pos_ok", 32'(pos_ok), 32'h1);
        check("t1_commits", 32'(commits), 32'd1);
        check("t1_no_rd", 32'(rd_seen), 32'h0);
        hs = 1'b0;
        tick();

`ifdef JTS16_ROWSCR_EN
        // Layer 1 fetch, ok in the 4th request cycle.
        rowscr1_en = 1'b1; vdump = 9'h028; ok_lat = 4;
        rd_addrs.delete(); commits = 0;
        line_edge(lat);
        check("t2_lat", 32'(lat), 32'd7);
        check("t2_nreads", 32'(rd_addrs.size()), 32'd1);
        check("t2_addr", 32'(rd_addrs[0]), 32'h7C5);
        check("t2_hpos1", 32'(hpos1), 32'h2AA);
        check("t2_hpos2", 32'(hpos2), 32'h2BC);
        check("t2_vpos1", 32'(vpos1), 32'h045);
        check("t2_commits", 32'(commits), 32'd1);
        hs = 1'b0;
        tick();

        // Both layers; line 0x1F8 reads the last entry of each table.
        rowscr2_en = 1'b1; vdump = 9'h1F8; ok_lat = 2;
        rd_addrs.delete(); commits = 0;
        line_edge(lat);
        check("t3_lat", 32'(lat), 32'd7);
        check("t3_nreads", 32'(rd_addrs.size()), 32'd2);
        check("t3_addr0", 32'(rd_addrs[0]), 32'h7DF);
        check("t3_addr1", 32'(rd_addrs[1]), 32'h7FF);
        check("t3_hpos1", 32'(hpos1), 32'h28A);
        check("t3_hpos2", 32'(hpos2), 32'h2AA);
        check("t3_commits", 32'(commits), 32'd1);
        hs = 1'b0;
        tick();

        // New line while a request is pending: abandon, then refetch.
        rowscr2_en = 1'b0; vdump = 9'h028; ok_lat = 1000;
        rd_addrs.delete(); commits = 0;
        hs = 1'b1;
        for (int i = 0; i < 20 && !ram_rd; i++) tick();
        check("t4_req", 32'(ram_rd), 32'h1);
        repeat (2) tick();
        hs = 1'b0;
        tick();
        hs = 1'b1; vdump = 9'h050;
        tick();
        check("t4_rd_drop", 32'(ram_rd), 32'h0);
        check("t4_pos_low", 32'(pos_ok), 32'h0);
        ok_lat = 2;
        tick();
        check("t4_rd_again", 32'(ram_rd), 32'h1);
        check("t4_addr", 32'(ram_addr), 32'h7CA);
        for (int i = 0; i < 60 && !pos_ok; i++) tick();
        check("t4_pos_ok", 32'(pos_ok), 32'h1);
        check("t4_commits", 32'(commits), 32'd1);
        check("t4_hpos1", 32'(hpos1), 32'h29F);
        check("t4_nreads", 32'(rd_addrs.size()), 32'd2);
        hs = 1'b0;
        tick();

        // Reset asserted while layer 2 request is pending.
        rowscr1_en = 1'b0; rowscr2_en = 1'b1; vdump = 9'h0F0; ok_lat = 1000;
        hs = 1'b1;
        for (int i = 0; i < 20 && !ram_rd; i++) tick();
        check("t5_req", 32'(ram_rd), 32'h1);
        check("t5_addr", 32'(ram_addr), 32'h7FE);
        #2;
        rst = 1'b1; hs = 1'b0;
        #1;
        check("t5_rd_async", 32'(ram_rd), 32'h0);
        check("t5_addr_rst", 32'(ram_addr), 32'h0);
        check("t5_pos_rst", 32'(pos_ok), 32'h0);
        check("t5_h_rst", 32'({hpos1, hpos2}), 32'h0);
        check("t5_v_rst", 32'({vpos1, vpos2}), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        c0 = commits;
        repeat (6) tick();
        check("t5_pos_stays_low", 32'(pos_ok), 32'h0);
        check("t5_no_commit", 32'(commits - c0), 32'd0);
        rowscr2_en = 1'b0; ok_lat = 1;
        line_edge(lat);
        check("t5_lat", 32'(lat), 32'd3);
        check("t5_hpos1", 32'(hpos1), 32'h123);
        hs = 1'b0;
        tick();
`else
        // Fetch logic absent: enables have no effect.
        rowscr1_en = 1'b1; rowscr2_en = 1'b1; scr1_hpos = 16'hFD5A;
        rd_seen = 1'b0;
        line_edge(lat);
        check("t6_lat", 32'(lat), 32'd1);
        check("t6_hpos1", 32'(hpos1), 32'h15A);
        check("t6_no_rd", 32'(rd_seen), 32'h0);
        check("t6_addr", 32'(ram_addr), 32'h0);
        hs = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_pos_rst", 32'(pos_ok), 32'h0);
        check("t6_h_rst", 32'(hpos1), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        check("t6_pos_stays_low", 32'(pos_ok), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jts16_rowscr.md
JTS16_ROWSCR -- requirements
Module: jts16_rowscr

Interface
REQ-001 SHALL have parameter MODEL, default 1, where 0 = S16A (row scroll never fetched) and 1 = S16B.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port hs, input, 1 bit: horizontal sync, sampled on clk.
REQ-005 SHALL have port vdump, input, 9 bits: current video line.
REQ-006 SHALL have ports scr1_hpos, scr2_hpos, scr1_vpos and scr2_vpos, input, 16 bits each: scroll registers from the register block.
REQ-007 SHALL have ports rowscr1_en and rowscr2_en, input, 1 bit each: row-scroll enables.
REQ-008 SHALL have port ram_addr, output, 11 bits [11:1]: text RAM word address.
REQ-009 SHALL have port ram_rd, output, 1 bit: read request.
REQ-010 SHALL have port ram_din, input, 16 bits: read data.
REQ-011 SHALL have port ram_ok, input, 1 bit: read acknowledge.
REQ-012 SHALL have ports hpos1 and hpos2, output, 10 bits each; and vpos1 and vpos2, output, 9 bits each: per-line effective scroll for layers 1 and 2.
REQ-013 SHALL have port pos_ok, output, 1 bit: high while the h/vpos outputs hold a complete set for the current line.

Function
REQ-014 SHALL detect the line start as an hs rising edge, using a one-register delay.
REQ-015 SHALL, at line start, latch nv1 = scr1_vpos[8:0] and nv2 = scr2_vpos[8:0].
REQ-016 SHALL, at line start, latch nh1 = scr1_hpos[9:0] and nh2 = scr2_hpos[9:0], and then enter FETCH1.
REQ-017 SHALL use FSM states IDLE, FETCH1, FETCH2 and COMMIT.
REQ-018 SHALL, in FETCH1, skip to FETCH2 when MODEL==0 or rowscr1_en==0; otherwise it SHALL drive ram_rd=1 with ram_addr = 11'h7C0 + vdump[7:3].
REQ-019 SHALL, in FETCH2, apply the same rule with rowscr2_en and base 11'h7E0.
REQ-020 SHALL hold ram_addr stable and ram_rd high until the cycle in which ram_ok=1.
REQ-021 SHALL, in the cycle ram_ok=1, load ram_din[9:0] into nh1 (FETCH1) or nh2 (FETCH2), drop ram_rd on the next cycle and advance state.
REQ-022 SHALL, in COMMIT, copy nh1, nh2, nv1 and nv2 to the outputs in a single cycle, set pos_ok=1 and go to IDLE.
REQ-023 SHALL keep the outputs unchanged everywhere except COMMIT, so no partial update is ever visible.
REQ-024 SHALL clear pos_ok in the cycle a line start is detected.
REQ-025 SHALL latency: with no fetches, pos_ok rises 3 clk after the hs edge is detected; each fetch adds (ram_ok wait + 1) clk.
REQ-026 SHALL, on a line start while in FETCH1 or FETCH2, abandon the fetch: ram_rd drops for one cycle, nothing is committed, and the FSM restarts from REQ-015 on the new line.
REQ-027 SHALL ignore ram_ok while ram_rd=0.
REQ-028 SHALL not register a further line start while hs stays high.
REQ-029 SHALL wrap the table index on vdump[7:3], so line 256 reads entry 0.

Reset
REQ-030 SHALL, while rst=1, force state=IDLE and ram_rd=0.
REQ-031 SHALL, while rst=1, force ram_addr=0, pos_ok=0, all h/vpos outputs and latches to 0, and the hs delay register to 0.
REQ-032 SHALL, on rst asserted mid-fetch, drop ram_rd within the same cycle (asynchronously) and emit no commit.

Configuration
REQ-033 SHALL, with macro JTS16_ROWSCR_EN defined, fetch row scroll as in REQ-018 to REQ-021.
REQ-034 SHALL, without JTS16_ROWSCR_EN, omit FETCH1 and FETCH2 logic, tie ram_rd=0 and ram_addr=0, and treat rowscr1_en and rowscr2_en as 0; COMMIT then follows the line start by 1 clk.

Structure
REQ-035 SHALL place the FSM state enumeration and the table bases ROWSCR1_BASE=11'h7C0 and ROWSCR2_BASE=11'h7E0 in shared package jts16_scr_pkg.
REQ-036 SHALL be a single module with no sub-module; the fetch is a two-state sequence too small to split.

Verification
REQ-037 SHALL cover: MODEL=1, enables=0, scr1_hpos=16'h0123, scr1_vpos=16'h0045, hs edge -> hpos1=10'h123, vpos1=9'h045, pos_ok high 3 clk later, ram_rd never high.
REQ-038 SHALL cover: rowscr1_en=1, vdump=9'h028, ram_ok after 4 clk with ram_din=16'h02AA -> ram_addr=11'h7C5, hpos1=10'h2AA, hpos2=scr2_hpos[9:0].
REQ-039 SHALL cover: both enables set, vdump=9'h1F8 -> reads 11'h7DF then 11'h7FF, in that order, one commit.
REQ-040 SHALL cover: a second hs edge while ram_rd waits -> no commit, ram_rd low 1 clk, then a new fetch at the new vdump address.
REQ-041 SHALL cover: rst pulsed during FETCH2 -> ram_rd=0 immediately, all outputs 0, pos_ok=0 until the next full line.
REQ-042 SHALL cover: build without JTS16_ROWSCR_EN, rowscr1_en=1 -> ram_rd stays 0, hpos1=scr1_hpos[9:0].
